// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer and the graph/text blocks.
// master drives the game events; slave (the controller) drives the status outputs.
interface pong_game_ctrl_if;
   logic       refr_tick;
   logic       start;
   logic       miss;
   logic       hit_left;
   logic       hit_right;
   logic       graph_still;
   logic       game_over;
   logic [1:0] state;
   logic [2:0] balls_left;
   logic [7:0] rally;
   logic [7:0] best_rally;

   modport master (
      output refr_tick, start, miss, hit_left, hit_right,
      input  graph_still, game_over, state, balls_left, rally, best_rally
   );

   modport slave (
      input  refr_tick, start, miss, hit_left, hit_right,
      output graph_still, game_over, state, balls_left, rally, best_rally
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new-game / play / re-serve / game-over phases, ball and rally tracking.
// Define PONG_CTRL_RALLY_EN to build the rally counter, best-rally register and hit detectors.
module pong_game_ctrl #(
   parameter int BALLS       = 3,
   parameter int DELAY_TICKS = 120
) (
   input  logic            clk,
   input  logic            reset,
   pong_game_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      NEWGAME = 2'b00,
      PLAY    = 2'b01,
      NEWBALL = 2'b10,
      OVER    = 2'b11
   } state_t;

   localparam logic [2:0] BALLS_INIT = 3'(BALLS);
   localparam logic [7:0] DELAY_INIT = 8'(DELAY_TICKS);

   state_t     state_r, state_n;
   logic [2:0] balls_r, balls_n;
   logic [7:0] timer_r, timer_n;
   logic       graph_still_r;
   logic       game_over_r;
   logic       start_q, miss_q;
   logic       start_rise, miss_rise;
   logic [7:0] rally_r, best_r;

   assign start_rise = bus.start & ~start_q;
   assign miss_rise  = bus.miss  & ~miss_q;

   // State, ball count, pause timer and the registered phase outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r       <= NEWGAME;
         balls_r       <= BALLS_INIT;
         timer_r       <= 8'd0;
         graph_still_r <= 1'b1;
         game_over_r   <= 1'b0;
         start_q       <= 1'b0;
         miss_q        <= 1'b0;
      end else begin
         state_r       <= state_n;
         balls_r       <= balls_n;
         timer_r       <= timer_n;
         graph_still_r <= (state_n != PLAY);
         game_over_r   <= (state_n == OVER);
         start_q       <= bus.start;
         miss_q        <= bus.miss;
      end
   end

   always_comb begin
      state_n = state_r;
      balls_n = balls_r;
      timer_n = timer_r;
      case (state_r)
         NEWGAME: begin
            balls_n = BALLS_INIT;
            timer_n = 8'd0;
            if (start_rise) state_n = PLAY;
         end
         PLAY: begin
            if (miss_rise) begin
               balls_n = balls_r - 3'd1;
               timer_n = DELAY_INIT;
               state_n = (balls_r == 3'd1) ? OVER : NEWBALL;
            end
         end
         NEWBALL, OVER: begin
            // Pauses are counted in frames; the tick on the entry cycle never reaches here
            if (bus.refr_tick) begin
               if (timer_r <= 8'd1) begin
                  timer_n = 8'd0;
                  if (state_r == NEWBALL) begin
                     state_n = PLAY;
                  end else begin
                     state_n = NEWGAME;
                     balls_n = BALLS_INIT;
                  end
               end else begin
                  timer_n = timer_r - 8'd1;
               end
            end
         end
         default: state_n = NEWGAME;
      endcase
   end

`ifdef PONG_CTRL_RALLY_EN
   logic       hit_left_q, hit_right_q;
   logic       hit_rise;
   logic [7:0] rally_n, best_n;

   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h99)           r = v;
      else if (v[3:0] == 4'h9)  r = {v[7:4] + 4'h1, 4'h0};
      else                      r = {v[7:4], v[3:0] + 4'h1};
      return r;
   endfunction

   assign hit_rise = (bus.hit_left  & ~hit_left_q) |
                     (bus.hit_right & ~hit_right_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_left_q  <= 1'b0;
         hit_right_q <= 1'b0;
         rally_r     <= 8'h00;
         best_r      <= 8'h00;
      end else begin
         hit_left_q  <= bus.hit_left;
         hit_right_q <= bus.hit_right;
         rally_r     <= rally_n;
         best_r      <= best_n;
      end
   end

   // A miss in the same cycle as a hit wins and the hit is dropped
   always_comb begin
      rally_n = rally_r;
      case (state_r)
         NEWGAME: rally_n = 8'h00;
         PLAY: begin
            if (miss_rise)     rally_n = 8'h00;
            else if (hit_rise) rally_n = bcd_inc_sat(rally_r);
         end
         default: rally_n = rally_r;
      endcase
      best_n = (rally_n > best_r) ? rally_n : best_r;
   end
`else
   logic unused_hits;
   assign unused_hits = bus.hit_left ^ bus.hit_right;
   assign rally_r     = 8'h00;
   assign best_r      = 8'h00;
`endif

   assign bus.state       = state_r;
   assign bus.graph_still = graph_still_r;
   assign bus.game_over   = game_over_r;
   assign bus.balls_left  = balls_r;
   assign bus.rally       = rally_r;
   assign bus.best_rally  = best_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game scenarios plus random play, checked
// every cycle against a rule-level model of the game.
module tb_pong_game_ctrl;
   localparam int BALLS = 3;
   localparam int DT    = 4;
`ifdef PONG_CTRL_RALLY_EN
   localparam bit RALLY = 1'b1;
`else
   localparam bit RALLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pong_game_ctrl_if ifc();

   pong_game_ctrl #(.BALLS(BALLS), .DELAY_TICKS(DT)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (ifc.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: phase code, balls, rally as a decimal count, best rally, frames left in pause
   int m_phase, m_balls, m_rally, m_best, m_ticks;
   bit p_start, p_miss, p_hl, p_hr;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit sr, mr, hr;
      if (!reset) begin
         m_phase = 0; m_balls = BALLS; m_rally = 0; m_best = 0; m_ticks = 0;
         p_start = 0; p_miss = 0; p_hl = 0; p_hr = 0;
         return;
      end
      sr = ifc.start && !p_start;
      mr = ifc.miss && !p_miss;
      hr = (ifc.hit_left && !p_hl) || (ifc.hit_right && !p_hr);
      case (m_phase)
         0: if (sr) m_phase = 1;
         1: begin
            if (mr) begin
               m_balls--;
               m_rally = 0;
               m_ticks = DT;
               m_phase = (m_balls == 0) ? 3 : 2;
            end else if (hr && RALLY) begin
               if (m_rally < 99) m_rally++;
               if (m_rally > m_best) m_best = m_rally;
            end
         end
         default: begin
            if (ifc.refr_tick) begin
               m_ticks--;
               if (m_ticks == 0) begin
                  if (m_phase == 3) m_balls = BALLS;
                  m_phase = (m_phase == 2) ? 1 : 0;
               end
            end
         end
      endcase
      p_start = ifc.start; p_miss = ifc.miss; p_hl = ifc.hit_left; p_hr = ifc.hit_right;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk("state",      8'(ifc.state),      8'(m_phase));
      chk("balls_left", 8'(ifc.balls_left), 8'(m_balls));
      chk("rally",      ifc.rally,          to_bcd(m_rally));
      chk("best_rally", ifc.best_rally,     to_bcd(m_best));
      chk("graph_still",8'(ifc.graph_still),8'(m_phase != 1));
      chk("game_over",  8'(ifc.game_over),  8'(m_phase == 3));
   endtask

   task automatic hit(input bit left);
      if (left) ifc.hit_left = 1'b1; else ifc.hit_right = 1'b1;
      step();
      ifc.hit_left = 1'b0; ifc.hit_right = 1'b0;
      step();
   endtask

   task automatic miss_pulse();
      ifc.miss = 1'b1; step(); ifc.miss = 1'b0; step();
   endtask

   task automatic start_pulse();
      ifc.start = 1'b1; step(); ifc.start = 1'b0; step();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         ifc.refr_tick = 1'b1; step(); ifc.refr_tick = 1'b0; step();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; step(); reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      ifc.refr_tick = 1'b0; ifc.start = 1'b0; ifc.miss = 1'b0;
      ifc.hit_left = 1'b0; ifc.hit_right = 1'b0;
      step(); step();
      chk("reset_state", 8'(ifc.state), 8'h00);
      chk("reset_balls", 8'(ifc.balls_left), 8'd3);
      chk("reset_still", 8'(ifc.graph_still), 8'd1);
      reset = 1'b1;

      // Start a game
      ifc.start = 1'b1; step();
      chk("start_play", 8'(ifc.state), 8'h01);
      chk("start_still", 8'(ifc.graph_still), 8'd0);
      ifc.start = 1'b0; step();

      // Twelve hits then a miss
      for (int i = 0; i < 12; i++) hit($urandom_range(0, 1) == 1);
      chk("rally12", ifc.rally, RALLY ? 8'h12 : 8'h00);
      chk("best12",  ifc.best_rally, RALLY ? 8'h12 : 8'h00);
      ifc.miss = 1'b1; step();
      chk("miss_newball", 8'(ifc.state), 8'h02);
      chk("miss_balls", 8'(ifc.balls_left), 8'd2);
      chk("miss_rally0", ifc.rally, 8'h00);
      ifc.miss = 1'b0; step();

      // Re-serve pause with start presses that must be ignored
      start_pulse();
      ticks(DT - 1);
      chk("pause_hold", 8'(ifc.state), 8'h02);
      start_pulse();
      ticks(1);
      chk("pause_exit", 8'(ifc.state), 8'h01);

      // Lose the remaining balls and ride through game over with start held
      miss_pulse(); ticks(DT);
      miss_pulse();
      chk("over_state", 8'(ifc.state), 8'h03);
      chk("over_flag",  8'(ifc.game_over), 8'd1);
      chk("over_balls", 8'(ifc.balls_left), 8'd0);
      ifc.start = 1'b1;
      ticks(DT);
      chk("over_exit", 8'(ifc.state), 8'h00);
      chk("over_refill", 8'(ifc.balls_left), 8'd3);
      for (int i = 0; i < 5; i++) step();
      chk("held_start", 8'(ifc.state), 8'h00);
      ifc.start = 1'b0; step();
      start_pulse();
      chk("restart", 8'(ifc.state), 8'h01);

      // Saturation, then a simultaneous miss and hit
      do_reset(); start_pulse();
      for (int i = 0; i < 105; i++) hit(i[0]);
      chk("sat99", ifc.rally, RALLY ? 8'h99 : 8'h00);
      ifc.miss = 1'b1; ifc.hit_right = 1'b1; step();
      chk("both_rally", ifc.rally, 8'h00);
      chk("both_balls", 8'(ifc.balls_left), 8'd2);
      ifc.miss = 1'b0; ifc.hit_right = 1'b0; step();

      // Reset mid-rally
      do_reset(); start_pulse();
      for (int i = 0; i < 7; i++) hit(1'b1);
      chk("rally07", ifc.rally, RALLY ? 8'h07 : 8'h00);
      reset = 1'b0; step(); reset = 1'b1;
      chk("midrst_state", 8'(ifc.state), 8'h00);
      chk("midrst_best",  ifc.best_rally, 8'h00);

      // Random play including occasional resets
      for (int i = 0; i < 2000; i++) begin
         reset         = ($urandom_range(0, 299) != 0);
         ifc.refr_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0)  ifc.start     = ~ifc.start;
         if ($urandom_range(0, 11) == 0) ifc.miss      = ~ifc.miss;
         if ($urandom_range(0, 2) == 0)  ifc.hit_left  = ~ifc.hit_left;
         if ($urandom_range(0, 2) == 0)  ifc.hit_right = ~ifc.hit_right;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-level sequencer for the pong datapath. It drives `graph_still` into the graph block, which freezes the ball and paddles and clears their scores. It consumes the graph's `miss`, `hit_left` and `hit_right` flags together with the 60 Hz refresh tick. It tracks remaining balls, the current rally length and the best rally, and steps through new-game, play, re-serve and game-over phases for the text/overlay logic.

## Interface
- `BALLS`, default 3: balls per game, range 1–7.
- `DELAY_TICKS`, default 120: refresh ticks spent in re-serve and game-over pauses, range 1–255 (120 ticks = 2 s at 60 Hz).
- `clk` input 1: system clock.
- `reset` input 1: reset is synchronous and active-low; sampled on the rising edge of `clk`.
- `refr_tick` input 1: one-clock pulse per frame (at pixel y=481, x=0).
- `start` input 1: start button, level.
- `miss` input 1: level from the graph block.
- `hit_left` input 1: level from the graph block.
- `hit_right` input 1: level from the graph block.
- `graph_still` output 1: freezes and re-centres the graph datapath.
- `game_over` output 1: high in OVER.
- `state` output 2: 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
- `balls_left` output 3: remaining balls.
- `rally` output 8: current rally, two-digit BCD.
- `best_rally` output 8: best rally since reset, two-digit BCD.

## Operation
Edge detection:
- `start`, `miss`, `hit_left` and `hit_right` are each registered once (`*_q`, reset 0).
- `start_rise = start & ~start_q`.
- `miss_rise = miss & ~miss_q`.
- `hit_rise = (hit_left & ~hit_left_q) | (hit_right & ~hit_right_q)`.

FSM. All outputs are registered. `graph_still` = 1 in every state except PLAY.
- **NEWGAME** (reset state)
  - `balls_left` = BALLS, `rally` = 0.
  - `start_rise` → PLAY.
- **PLAY**
  - `hit_rise` increments `rally` in BCD, saturating at 8'h99.
  - `miss_rise`:
    - `balls_left` decrements by 1 and `rally` clears to 0.
    - The timer loads DELAY_TICKS.
    - If the old `balls_left` = 1 → OVER, else → NEWBALL.
  - `start` is ignored.
- **NEWBALL**
  - On `refr_tick`: if timer = 1 → PLAY (timer → 0), else timer decrements.
  - `start` is ignored.
- **OVER**
  - `game_over` = 1.
  - Timer counts exactly as in NEWBALL; on expiry → NEWGAME.
  - A `start_rise` during OVER is ignored, so a fresh press is needed in NEWGAME.

Best rally:
- Whenever the updated `rally` value exceeds `best_rally` (BCD compare equals binary compare), `best_rally` takes it in the same cycle.

Arithmetic:
- BCD increment: low nibble 9 → 0 with carry into the high nibble.
- 8'h99 holds at 8'h99.
- `balls_left` never underflows because OVER is entered at 1.
- Timer is 8 bits and only nonzero in NEWBALL or OVER.

Simultaneous events:
- `miss_rise` and `hit_rise` in the same cycle: miss wins, `rally` → 0, and the hit is discarded.
- `refr_tick` on the same cycle as entry into NEWBALL or OVER is not counted; counting begins the next cycle.

## Timing
- State and outputs update on the `clk` edge after the triggering input edge is registered.
- An input asserted at cycle n gives `*_rise` at n, and the state or output change is visible at n+1.
- NEWBALL and OVER each last exactly DELAY_TICKS `refr_tick` pulses. The exit happens on the cycle after the DELAY_TICKS-th pulse.
- Reset values (`reset` = 0 at a rising edge):
  - `state` = NEWGAME, `graph_still` = 1, `game_over` = 0.
  - `balls_left` = BALLS, `rally` = 0, `best_rally` = 0.
  - Timer = 0, all `*_q` = 0.
- Reset mid-operation: any state returns to NEWGAME on the next edge and overrides all events in that cycle.

## Configuration
- `PONG_CTRL_RALLY_EN` defined:
  - Rally counter, best-rally register and hit edge detectors are built.
- Not defined:
  - `rally` and `best_rally` are tied to 8'h00.
  - `hit_left` and `hit_right` are unused.
  - FSM, ball and timer behaviour is unchanged.

## Test plan
- Reset, then one `start` pulse → `state` 00→01, `graph_still` 1→0, `balls_left` = 3.
- In PLAY, 12 `hit_left`/`hit_right` rising edges → `rally` = 8'h12 and `best_rally` = 8'h12. Then a `miss` edge → `rally` = 0, `best_rally` = 8'h12, `balls_left` = 2, `state` = NEWBALL, `graph_still` = 1.
- In NEWBALL with DELAY_TICKS = 4: 3 `refr_tick` pulses → still NEWBALL; the 4th pulse → PLAY on the next cycle. `start` pulses during the wait have no effect.
- Three misses from NEWGAME → OVER with `game_over` = 1 and `balls_left` = 0. After DELAY_TICKS ticks → NEWGAME with `balls_left` = 3. A `start` held high across the transition does not restart; a new rising edge does.
- 105 hit edges with no miss → `rally` saturates at 8'h99. A `miss` and a hit edge in the same cycle → `rally` = 0 and `balls_left` decrements.
- `reset` = 0 for one cycle while in PLAY with `rally` = 8'h07 → next cycle shows the full reset state. With `PONG_CTRL_RALLY_EN` undefined, hit edges leave `rally` and `best_rally` at 0.
